// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and shifts it out LSB first,
// with a ready/valid load handshake that allows gap-free back-to-back words.
module piso_tx #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               last_bit;
  logic               accept;

  // Outputs are decoded from registered state only; load_ready additionally sees rst
  // so nothing is accepted while reset is held.
  always_comb begin
    last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
    load_ready = !rst && ((state_q == S_IDLE) || last_bit);
    busy       = (state_q == S_SHIFT);
    bit_valid  = busy;
    done       = last_bit;
    serial_out = busy ? shreg_q[0] : IDLE_LEVEL;
  end

  assign accept = load_valid && load_ready;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (accept) begin
          // A word offered in the last-bit cycle follows without an idle gap.
          shreg_d = data_in;
          cnt_d   = '0;
        end else if (last_bit) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
